// File: rtl/fb_sdram_reader.sv
// fb_sdram_reader: Avalon-MM burst read master feeding a framebuffer stream
module fb_sdram_reader #(
    parameter int ADDR_WIDTH        = 32,
    parameter int DATA_WIDTH        = 64,
    parameter int BURST_COUNT_WIDTH = 8,
    parameter int MAX_BURST         = 16,
    parameter int FIFO_DEPTH        = 64,
    parameter int WORDS_WIDTH       = 24
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         frame_start_i,
    input  logic [ADDR_WIDTH-1:0]        base_addr_i,
    input  logic [WORDS_WIDTH-1:0]       frame_words_i,
    output logic                         busy_o,
    output logic [ADDR_WIDTH-1:0]        address_o,
    output logic [BURST_COUNT_WIDTH-1:0] burst_count_o,
    output logic [DATA_WIDTH/8-1:0]      byte_enable_o,
    output logic                         read_o,
    output logic                         write_o,
    output logic [DATA_WIDTH-1:0]        write_data_o,
    input  logic                         wait_request_i,
    input  logic [DATA_WIDTH-1:0]        read_data_i,
    input  logic                         read_data_val_i,
    output logic [DATA_WIDTH-1:0]        data_o,
    output logic                         valid_o,
    input  logic                         ready_i,
    output logic                         sop_o,
    output logic                         eop_o
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int PW    = $clog2(FIFO_DEPTH);
    localparam int CW    = PW + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, REQ, DRAIN} state_t;

    state_t                         state;
    logic [ADDR_WIDTH-1:0]          addr;
    logic [WORDS_WIDTH-1:0]         req_left;
    logic [WORDS_WIDTH-1:0]         load_left;
    logic                           first;
    logic [CW-1:0]                  outstanding;
    logic [CW-1:0]                  used;
    logic [PW-1:0]                  wr_ptr;
    logic [PW-1:0]                  rd_ptr;
    logic [DATA_WIDTH-1:0]          mem [FIFO_DEPTH];
    logic [BURST_COUNT_WIDTH-1:0]   len;
    logic                           room;
    logic                           start;
    logic                           accept;
    logic                           push;
    logic                           pop;
    logic                           xfer;

    assign byte_enable_o = '1;
    assign write_o       = 1'b0;
    assign write_data_o  = '0;

    // burst sizing, credit test and handshake qualifiers
    always_comb begin
        len    = (req_left < WORDS_WIDTH'(MAX_BURST)) ? req_left[BURST_COUNT_WIDTH-1:0]
                                                      : BURST_COUNT_WIDTH'(MAX_BURST);
        room   = (WORDS_WIDTH'(FIFO_DEPTH) - WORDS_WIDTH'(used) - WORDS_WIDTH'(outstanding))
                 >= WORDS_WIDTH'(len);
        start  = (state == IDLE) && frame_start_i && (frame_words_i != '0);
        accept = read_o && !wait_request_i;
        push   = read_data_val_i;
        pop    = (used != '0) && (!valid_o || ready_i);
        xfer   = valid_o && ready_i;
    end

    // FIFO storage; returned data is always written, credit guarantees space
    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr] <= read_data_i;
    end

    // FIFO pointers, occupancy and words-in-flight tracking
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            used        <= '0;
            outstanding <= '0;
        end else begin
            wr_ptr      <= wr_ptr + PW'(push);
            rd_ptr      <= rd_ptr + PW'(pop);
            used        <= used + CW'(push) - CW'(pop);
            outstanding <= outstanding + (accept ? CW'(burst_count_o) : CW'(0)) - CW'(push);
        end
    end

    // show-ahead output register with frame markers computed at load time
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_o    <= '0;
            valid_o   <= 1'b0;
            sop_o     <= 1'b0;
            eop_o     <= 1'b0;
            load_left <= '0;
            first     <= 1'b0;
        end else if (start) begin
            load_left <= frame_words_i;
            first     <= 1'b1;
        end else if (pop) begin
            data_o    <= mem[rd_ptr];
            valid_o   <= 1'b1;
            sop_o     <= first;
            eop_o     <= (load_left == WORDS_WIDTH'(1));
            load_left <= load_left - WORDS_WIDTH'(1);
            first     <= 1'b0;
        end else if (xfer) begin
            valid_o   <= 1'b0;
            sop_o     <= 1'b0;
            eop_o     <= 1'b0;
        end
    end

    // request FSM: issue bursts only when the FIFO can absorb them, then drain
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state         <= IDLE;
            busy_o        <= 1'b0;
            read_o        <= 1'b0;
            address_o     <= '0;
            burst_count_o <= '0;
            addr          <= '0;
            req_left      <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    addr     <= base_addr_i;
                    req_left <= frame_words_i;
                    busy_o   <= 1'b1;
                    state    <= ISSUE;
                end
                ISSUE: if (room) begin
                    read_o        <= 1'b1;
                    address_o     <= addr;
                    burst_count_o <= len;
                    state         <= REQ;
                end
                REQ: if (accept) begin
                    read_o   <= 1'b0;
                    addr     <= addr + ADDR_WIDTH'(burst_count_o) * ADDR_WIDTH'(BYTES);
                    req_left <= req_left - WORDS_WIDTH'(burst_count_o);
                    state    <= (req_left == WORDS_WIDTH'(burst_count_o)) ? DRAIN : ISSUE;
                end
                DRAIN: if (xfer && eop_o) begin
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fb_sdram_reader.sv
// tb_fb_sdram_reader: randomized SDRAM slave model and frame scoreboard for fb_sdram_reader
module tb_fb_sdram_reader;
    localparam int MAXB  = 16;
    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        frame_start_i = 1'b0;
    logic [31:0] base_addr_i = '0;
    logic [23:0] frame_words_i = '0;
    logic        busy_o;
    logic [31:0] address_o;
    logic [7:0]  burst_count_o;
    logic [7:0]  byte_enable_o;
    logic        read_o;
    logic        write_o;
    logic [63:0] write_data_o;
    logic        wait_request_i = 1'b0;
    logic [63:0] read_data_i = '0;
    logic        read_data_val_i = 1'b0;
    logic [63:0] data_o;
    logic        valid_o;
    logic        ready_i = 1'b0;
    logic        sop_o;
    logic        eop_o;

    always #5 clk = ~clk;

    fb_sdram_reader dut (
        .clk_i(clk), .rst_i(rst_i), .frame_start_i(frame_start_i), .base_addr_i(base_addr_i),
        .frame_words_i(frame_words_i), .busy_o(busy_o), .address_o(address_o),
        .burst_count_o(burst_count_o), .byte_enable_o(byte_enable_o), .read_o(read_o),
        .write_o(write_o), .write_data_o(write_data_o), .wait_request_i(wait_request_i),
        .read_data_i(read_data_i), .read_data_val_i(read_data_val_i), .data_o(data_o),
        .valid_o(valid_o), .ready_i(ready_i), .sop_o(sop_o), .eop_o(eop_o)
    );

    int checks = 0, errors = 0;
    int wait_pct = 0, rdv_pct = 100, rdy_pct = 100, wait_hold = 0;
    int stall_cnt = 0, burst_cnt = 0, occ = 0, max_occ = 0;
    logic        prev_stall = 1'b0, eop_pend = 1'b0;
    logic [31:0] prev_addr;
    logic [7:0]  prev_bc;
    logic [31:0] exp_ba[$];
    int          exp_bl[$];
    logic [65:0] exp_w[$];
    logic [31:0] sq[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] word_at(input logic [31:0] a);
        return {a, a ^ 32'hA5A5_5A5A};
    endfunction

    // reference: a frame is n consecutive words from base, cut into MAXB-word bursts
    task automatic model_frame(input logic [31:0] base, input int n);
        logic [31:0] a;
        int rem, l;
        a = base;
        rem = n;
        for (int i = 0; i < n; i++) exp_w.push_back({word_at(base + 32'(i * 8)), i == 0, i == n - 1});
        while (rem > 0) begin
            l = (rem < MAXB) ? rem : MAXB;
            exp_ba.push_back(a);
            exp_bl.push_back(l);
            a = a + 32'(l * 8);
            rem = rem - l;
        end
    endtask

    // slave + sink model: decide inputs for the next edge, then score what that edge transfers
    always @(negedge clk) begin
        logic [65:0] e;
        if (!rst_i) begin
            if (eop_pend) begin
                check("busy_after_eop", busy_o, 0);
                eop_pend = 1'b0;
            end
            if (prev_stall) begin
                check("stall_read", read_o, 1);
                check("stall_addr", address_o, prev_addr);
                check("stall_bc", burst_count_o, prev_bc);
            end
            if (sq.size() > 0 && $urandom_range(99) < rdv_pct) begin
                read_data_val_i = 1'b1;
                read_data_i = word_at(sq.pop_front());
                occ++;
            end else begin
                read_data_val_i = 1'b0;
                read_data_i = '0;
            end
            if (read_o && wait_hold > 0) begin
                wait_request_i = 1'b1;
                wait_hold--;
            end else wait_request_i = ($urandom_range(99) < wait_pct);
            prev_stall = read_o && wait_request_i;
            prev_addr = address_o;
            prev_bc = burst_count_o;
            if (prev_stall) stall_cnt++;
            if (read_o && !wait_request_i) begin
                burst_cnt++;
                check("burst_expected", exp_ba.size() != 0, 1);
                if (exp_ba.size() != 0) begin
                    check("burst_addr", address_o, exp_ba.pop_front());
                    check("burst_len", burst_count_o, exp_bl.pop_front());
                end
                for (int i = 0; i < burst_count_o; i++) sq.push_back(address_o + 32'(i * 8));
            end
            ready_i = ($urandom_range(99) < rdy_pct);
            if (valid_o && ready_i) begin
                check("word_expected", exp_w.size() != 0, 1);
                if (exp_w.size() != 0) begin
                    e = exp_w.pop_front();
                    check("data", data_o, e[65:2]);
                    check("sop", sop_o, e[1]);
                    check("eop", eop_o, e[0]);
                    if (e[0]) eop_pend = 1'b1;
                end
                occ--;
            end
            if (occ > max_occ) max_occ = occ;
        end
    end

    task automatic start_frame(input logic [31:0] base, input int n, input bit accepted);
        @(negedge clk);
        frame_start_i = 1'b1;
        base_addr_i = base;
        frame_words_i = 24'(n);
        if (accepted) model_frame(base, n);
        @(negedge clk);
        frame_start_i = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        int k;
        for (k = 0; k < limit; k++) begin
            @(negedge clk);
            if (exp_w.size() == 0 && !busy_o) break;
        end
        check("frame_done", k < limit, 1);
        check("bursts_all_issued", exp_ba.size(), 0);
    endtask

    initial begin
        int b0, k;
        repeat (3) @(negedge clk);
        check("rst_busy", busy_o, 0);
        check("rst_read", read_o, 0);
        check("rst_addr", address_o, 0);
        check("rst_bc", burst_count_o, 0);
        check("rst_valid", valid_o, 0);
        check("rst_sop", sop_o, 0);
        check("rst_eop", eop_o, 0);
        check("const_be", byte_enable_o, 8'hFF);
        check("const_write", write_o, 0);
        check("const_wdata", write_data_o, 0);
        rst_i = 1'b0;

        b0 = burst_cnt;
        start_frame(32'h1000, 40, 1);
        wait_done(2000);
        check("basic_bursts", burst_cnt - b0, 3);

        b0 = burst_cnt;
        stall_cnt = 0;
        wait_hold = 5;
        start_frame(32'h4000, 16, 1);
        wait_done(2000);
        check("stall_cycles", stall_cnt, 5);
        check("stall_bursts", burst_cnt - b0, 1);

        b0 = burst_cnt;
        rdy_pct = 0;
        start_frame(32'h8000, 200, 1);
        repeat (300) @(negedge clk);
        check("bp_bursts", burst_cnt - b0, 4);
        check("bp_read_idle", read_o, 0);
        rdy_pct = 100;
        wait_done(5000);
        check("bp_total_bursts", burst_cnt - b0, 13);

        start_frame(32'h5008, 1, 1);
        wait_done(500);

        b0 = burst_cnt;
        start_frame(32'h6000, 0, 0);
        repeat (5) @(negedge clk);
        check("zero_busy", busy_o, 0);
        check("zero_read", read_o, 0);
        check("zero_bursts", burst_cnt - b0, 0);

        wait_pct = 30; rdv_pct = 60; rdy_pct = 70;
        start_frame(32'h7000, 100, 1);
        repeat (10) @(negedge clk);
        check("midstart_busy", busy_o, 1);
        start_frame(32'h9000, 50, 0);
        wait_done(5000);

        wait_pct = 100; rdv_pct = 100; rdy_pct = 100;
        start_frame(32'hA000, 32, 1);
        for (k = 0; k < 50 && !read_o; k++) @(negedge clk);
        check("reached_req", read_o, 1);
        rst_i = 1'b1;
        @(posedge clk);
        #1;
        check("mrst_busy", busy_o, 0);
        check("mrst_read", read_o, 0);
        check("mrst_addr", address_o, 0);
        check("mrst_bc", burst_count_o, 0);
        check("mrst_valid", valid_o, 0);
        check("mrst_sop", sop_o, 0);
        check("mrst_eop", eop_o, 0);
        exp_w.delete(); exp_ba.delete(); exp_bl.delete(); sq.delete();
        prev_stall = 1'b0; eop_pend = 1'b0; occ = 0; wait_pct = 0;
        rst_i = 1'b0;
        start_frame(32'h2000, 16, 1);
        wait_done(1000);

        start_frame(32'hFFFF_FF80, 32, 1);
        wait_done(1000);

        for (int f = 0; f < 6; f++) begin
            wait_pct = $urandom_range(50);
            rdv_pct = $urandom_range(100, 30);
            rdy_pct = $urandom_range(100, 30);
            start_frame($urandom & 32'hFFFF_FFF8, $urandom_range(120, 1), 1);
            wait_done(20000);
        end

        check("no_overflow", max_occ <= DEPTH + 1, 1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
